term_ctrl: RTL and testbench

Byte-stream controller for the VGA character terminal. It accepts bytes over a valid/ready handshake, buffers them in a FIFO and parses a small ANSI subset. It then sequences the character generator's `data`/`dataStrobe`/`dataType` write port and holds its cursor and colour attribute registers. It sits between a byte source (UART, CPU port) and `vgachar`, replacing the constant attribute registers in the terminal top level.

---
 rtl/term_pkg.sv | 110 +++++++++++
 rtl/term_ctrl_if.sv | 13 +
 rtl/term_fifo.sv | 63 ++++++
 rtl/term_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_term_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/term_pkg.sv
// term_pkg: shared types and constants for the terminal byte-stream controller.
//   - FSM state and byte-class enums
//   - character codes (ESC, BS, LF, CR, FF) and CSI syntax bytes
//   - SGR / DEC private-mode code constants
//   - attribute bundle and its reset value
//   - palette / SGR / parameter helpers (only with TERM_CTRL_ESC_EN)
// Optional feature macro: TERM_CTRL_ESC_EN (ESC/CSI parsing and palette).
package term_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_LBRK  = 8'h5B;  // '['
    localparam logic [7:0] CH_QMARK = 8'h3F;  // '?'
    localparam logic [7:0] CH_SEMI  = 8'h3B;  // ';'
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_M     = 8'h6D;  // 'm'
    localparam logic [7:0] CH_H     = 8'h68;  // 'h'
    localparam logic [7:0] CH_L     = 8'h6C;  // 'l'
    localparam logic [7:0] CH_J     = 8'h4A;  // 'J'

    localparam logic [7:0] SGR_RESET  = 8'd0;
    localparam logic [7:0] SGR_UL_ON  = 8'd4;
    localparam logic [7:0] SGR_UL_OFF = 8'd24;
    localparam logic [7:0] SGR_FG0    = 8'd30;
    localparam logic [7:0] SGR_FG7    = 8'd37;
    localparam logic [7:0] SGR_BG0    = 8'd40;
    localparam logic [7:0] SGR_BG7    = 8'd47;
    localparam logic [7:0] DEC_CUR_BLK = 8'd12;
    localparam logic [7:0] DEC_CUR_VIS = 8'd25;
    localparam logic [7:0] CSI_ED_ALL  = 8'd2;   // ESC[2J

    typedef struct packed {
        logic        cur_vis;
        logic        cur_blk;
        logic        ul;
        logic [11:0] fg;
        logic [11:0] bg;
    } attr_t;

    localparam attr_t ATTR_RST = '{cur_vis: 1'b1, cur_blk: 1'b1, ul: 1'b0,
                                   fg: 12'hFFF, bg: 12'h000};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
`ifdef TERM_CTRL_ESC_EN
        , ST_ESC,
        ST_CSI
`endif
    } state_e;

    typedef enum logic [1:0] {CLS_DROP, CLS_PRINT, CLS_CTRL, CLS_ESC} cls_e;

    function automatic cls_e classify(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) return CLS_PRINT;
        if (b == CH_BS || b == CH_LF || b == CH_CR || b == CH_FF) return CLS_CTRL;
`ifdef TERM_CTRL_ESC_EN
        if (b == CH_ESC) return CLS_ESC;
`endif
        return CLS_DROP;
    endfunction

`ifdef TERM_CTRL_ESC_EN
    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'h000;
            3'd1:    return 12'hF00;
            3'd2:    return 12'h0F0;
            3'd3:    return 12'hFF0;
            3'd4:    return 12'h00F;
            3'd5:    return 12'hF0F;
            3'd6:    return 12'h0FF;
            default: return 12'hFFF;
        endcase
    endfunction

    // Cursor bits are deliberately untouched by SGR 0.
    function automatic attr_t sgr_apply(input attr_t a, input logic [7:0] code);
        attr_t r;
        r = a;
        if (code == SGR_RESET) begin
            r.ul = ATTR_RST.ul;
            r.fg = ATTR_RST.fg;
            r.bg = ATTR_RST.bg;
        end else if (code == SGR_UL_ON) begin
            r.ul = 1'b1;
        end else if (code == SGR_UL_OFF) begin
            r.ul = 1'b0;
        end else if (code >= SGR_FG0 && code <= SGR_FG7) begin
            r.fg = palette(3'(code - SGR_FG0));
        end else if (code >= SGR_BG0 && code <= SGR_BG7) begin
            r.bg = palette(3'(code - SGR_BG0));
        end
        return r;
    endfunction

    // Decimal accumulate, saturating at 255 so huge params can't alias onto valid codes.
    function automatic logic [7:0] param_acc(input logic [7:0] p, input logic [3:0] d);
        logic [11:0] t;
        t = 12'(p) * 12'd10 + 12'(d);
        return (t > 12'd255) ? 8'hFF : t[7:0];
    endfunction
`endif

endpackage

// File: rtl/term_ctrl_if.sv
// term_ctrl_if: byte-stream valid/ready handshake into term_ctrl.
//   rx_data  [7:0] byte from source
//   rx_valid       rx_data valid
//   rx_ready       sink can accept (byte taken when valid & ready at clk edge)
// master = byte source, slave = term_ctrl.
interface term_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/term_fifo.sv
// term_fifo: synchronous show-ahead FIFO with registered full/empty.
//   clk, reset  clock, synchronous active-high reset
//   push_i      write request (ignored while full)
//   wdata_i     write data
//   pop_i       read request (ignored while empty)
//   rdata_o     head entry, valid while !empty_o
//   full_o      registered full flag
//   empty_o     registered empty flag
// DEPTH must be a power of two so the pointers wrap for free.
module term_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/term_ctrl.sv
// term_ctrl: byte-stream front end for the vgachar character generator.
// Buffers incoming bytes, forwards printable/control bytes as strobed writes
// spaced at least STROBE_GAP cycles apart, and (optionally) parses a small
// ANSI CSI subset that drives cursor/colour attribute registers.
//   clk, reset      clock, synchronous active-high reset
//   rx              term_ctrl_if.slave byte stream (rx_data/rx_valid/rx_ready)
//   data/dataType   byte and class (0 printable, 1 control) to vgachar
//   dataStrobe      one-cycle write pulse
//   cursorVisible, cursorBlock, underline, fgColor, bgColor  attributes
//   busy            FIFO non-empty or FSM not idle
// Optional feature macro: TERM_CTRL_ESC_EN. Without it ESC is dropped like
// any other non-printable byte and attributes are tied to reset values.
module term_ctrl
    import term_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int STROBE_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    term_ctrl_if.slave  rx,
    output logic [7:0]  data,
    output logic        dataStrobe,
    output logic        dataType,
    output logic        cursorVisible,
    output logic        cursorBlock,
    output logic        underline,
    output logic [11:0] fgColor,
    output logic [11:0] bgColor,
    output logic        busy
);
    localparam int GW = $clog2(STROBE_GAP);
    // GAP dispatches the next byte itself on its last cycle, so the pop lands
    // STROBE_GAP-1 edges after the strobe and the next strobe exactly STROBE_GAP.
    localparam logic [GW-1:0] GAP_LOAD = GW'(STROBE_GAP - 2);

    logic [7:0] fifo_rdata;
    logic       fifo_full, fifo_empty, pop;

    term_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx.rx_valid),
        .wdata_i (rx.rx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx.rx_ready = ~fifo_full;

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    pend_q, pend_d;
    logic          pend_ctrl_q, pend_ctrl_d;
    logic [7:0]    data_q, data_d;
    logic          type_q, type_d;
    logic          strobe_q, strobe_d;

    cls_e cls;
    logic have_byte, dispatch;

    assign cls       = classify(fifo_rdata);
    assign have_byte = ~fifo_empty;
    assign dispatch  = (state_q == ST_IDLE) || (state_q == ST_GAP && gap_q == '0);

`ifdef TERM_CTRL_ESC_EN
    logic [7:0] param_q, param_d;
    logic       priv_q, priv_d;
    logic       dig_q, dig_d;   // a digit has been seen; '?' is ignored after it
    attr_t      attr_q, attr_d;
    logic       is_digit, csi_stay;

    assign is_digit = (fifo_rdata >= CH_0) && (fifo_rdata <= CH_9);
    assign csi_stay = is_digit || fifo_rdata == CH_QMARK || fifo_rdata == CH_SEMI;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (dispatch) begin
                    state_d = ST_IDLE;
                    if (have_byte) begin
                        case (cls)
                            CLS_PRINT, CLS_CTRL: state_d = ST_ISSUE;
`ifdef TERM_CTRL_ESC_EN
                            CLS_ESC:             state_d = ST_ESC;
`endif
                            default:             state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_ISSUE: state_d = ST_GAP;
`ifdef TERM_CTRL_ESC_EN
            ST_ESC: if (have_byte) state_d = (fifo_rdata == CH_LBRK) ? ST_CSI : ST_IDLE;
            ST_CSI: begin
                if (have_byte) begin
                    if (csi_stay)                                        state_d = ST_CSI;
                    else if (fifo_rdata == CH_J && param_q == CSI_ED_ALL) state_d = ST_ISSUE;
                    else                                                  state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-values
    always_comb begin
        pop         = 1'b0;
        gap_d       = gap_q;
        pend_d      = pend_q;
        pend_ctrl_d = pend_ctrl_q;
        data_d      = data_q;
        type_d      = type_q;
        strobe_d    = 1'b0;
`ifdef TERM_CTRL_ESC_EN
        param_d     = param_q;
        priv_d      = priv_q;
        dig_d       = dig_q;
        attr_d      = attr_q;
`endif
        if (state_q == ST_GAP && gap_q != '0) gap_d = gap_q - GW'(1);
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (dispatch && have_byte) begin
                    pop         = 1'b1;
                    pend_d      = fifo_rdata;
                    pend_ctrl_d = (cls == CLS_CTRL);
                end
            end
            ST_ISSUE: begin
                data_d   = pend_q;
                type_d   = pend_ctrl_q;
                strobe_d = 1'b1;
                gap_d    = GAP_LOAD;
            end
`ifdef TERM_CTRL_ESC_EN
            ST_ESC: begin
                if (have_byte) begin
                    pop     = 1'b1;
                    param_d = '0;
                    priv_d  = 1'b0;
                    dig_d   = 1'b0;
                end
            end
            ST_CSI: begin
                if (have_byte) begin
                    pop = 1'b1;
                    if (fifo_rdata == CH_QMARK) begin
                        if (!dig_q) priv_d = 1'b1;
                    end else if (is_digit) begin
                        dig_d   = 1'b1;
                        param_d = param_acc(param_q, fifo_rdata[3:0]);
                    end else if (fifo_rdata == CH_SEMI) begin
                        if (!priv_q) attr_d = sgr_apply(attr_q, param_q);
                        param_d = '0;
                    end else if (fifo_rdata == CH_M) begin
                        attr_d = sgr_apply(attr_q, param_q);
                    end else if ((fifo_rdata == CH_H || fifo_rdata == CH_L) && priv_q) begin
                        if (param_q == DEC_CUR_VIS) attr_d.cur_vis = (fifo_rdata == CH_H);
                        if (param_q == DEC_CUR_BLK) attr_d.cur_blk = (fifo_rdata == CH_H);
                    end else if (fifo_rdata == CH_J && param_q == CSI_ED_ALL) begin
                        pend_d      = CH_FF;
                        pend_ctrl_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q       <= '0;
            pend_q      <= '0;
            pend_ctrl_q <= 1'b0;
            data_q      <= '0;
            type_q      <= 1'b0;
            strobe_q    <= 1'b0;
`ifdef TERM_CTRL_ESC_EN
            param_q     <= '0;
            priv_q      <= 1'b0;
            dig_q       <= 1'b0;
            attr_q      <= ATTR_RST;
`endif
        end else begin
            gap_q       <= gap_d;
            pend_q      <= pend_d;
            pend_ctrl_q <= pend_ctrl_d;
            data_q      <= data_d;
            type_q      <= type_d;
            strobe_q    <= strobe_d;
`ifdef TERM_CTRL_ESC_EN
            param_q     <= param_d;
            priv_q      <= priv_d;
            dig_q       <= dig_d;
            attr_q      <= attr_d;
`endif
        end
    end

    assign data       = data_q;
    assign dataType   = type_q;
    assign dataStrobe = strobe_q;
    // Decoded from registered state only.
    assign busy       = ~fifo_empty | (state_q != ST_IDLE);

`ifdef TERM_CTRL_ESC_EN
    assign cursorVisible = attr_q.cur_vis;
    assign cursorBlock   = attr_q.cur_blk;
    assign underline     = attr_q.ul;
    assign fgColor       = attr_q.fg;
    assign bgColor       = attr_q.bg;
`else
    assign cursorVisible = ATTR_RST.cur_vis;
    assign cursorBlock   = ATTR_RST.cur_blk;
    assign underline     = ATTR_RST.ul;
    assign fgColor       = ATTR_RST.fg;
    assign bgColor       = ATTR_RST.bg;
`endif
endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: directed self-checking bench for term_ctrl.
// Expectations cover both builds (with and without TERM_CTRL_ESC_EN).
module tb_term_ctrl;
    localparam int DEPTH = 16;
    localparam int GAP   = 20;  // long enough that a 20-byte burst fills the FIFO
`ifdef TERM_CTRL_ESC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data;
    logic        dataStrobe, dataType, cursorVisible, cursorBlock, underline, busy;
    logic [11:0] fgColor, bgColor;

    term_ctrl_if rx();

    term_ctrl #(.FIFO_DEPTH(DEPTH), .STROBE_GAP(GAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .dataStrobe    (dataStrobe),
        .dataType      (dataType),
        .cursorVisible (cursorVisible),
        .cursorBlock   (cursorBlock),
        .underline     (underline),
        .fgColor       (fgColor),
        .bgColor       (bgColor),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    int         cyc = 0;
    int         first_acc = 0;
    bit         saw_full = 1'b0;
    logic [7:0] txq[$];
    logic [8:0] expq[$];
    logic [8:0] stb_q[$];
    int         stb_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dataStrobe) begin
            stb_q.push_back({dataType, data});
            stb_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
    endtask

    task automatic clear_stb();
        stb_q.delete();
        stb_cyc.delete();
        txq.delete();
    endtask

    // Plain-text expectation: printable -> type 0, BS/LF/CR/FF -> type 1, rest dropped.
    task automatic build_plain();
        expq.delete();
        foreach (txq[i]) begin
            if (txq[i] >= 8'h20 && txq[i] <= 8'h7E) expq.push_back({1'b0, txq[i]});
            else if (txq[i] == 8'h08 || txq[i] == 8'h0A || txq[i] == 8'h0D || txq[i] == 8'h0C)
                expq.push_back({1'b1, txq[i]});
        end
    endtask

    // Sends txq back to back; called #1 after a posedge, returns #1 after the last accept.
    task automatic send_q();
        bit r;
        int g;
        saw_full = 1'b0;
        for (int i = 0; i < txq.size(); i++) begin
            rx.rx_data  = txq[i];
            rx.rx_valid = 1'b1;
            g = 0;
            forever begin
                @(negedge clk);
                r = rx.rx_ready;
                if (!r) saw_full = 1'b1;
                @(posedge clk);
                if (r) break;
                g++;
                if (g > 2000) begin
                    check("send timeout", 1, 0);
                    break;
                end
            end
            #1;
            if (i == 0) first_acc = cyc;
        end
        rx.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({tag, " idle"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_strobes(input string tag);
        check({tag, " count"}, stb_q.size(), expq.size());
        for (int i = 0; i < expq.size() && i < stb_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(stb_q[i]), 32'(expq[i]));
    endtask

    task automatic check_spacing(input string tag);
        for (int i = 1; i < stb_cyc.size(); i++)
            check($sformatf("%s gap%0d", tag, i), stb_cyc[i] - stb_cyc[i-1], GAP);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rx.rx_data  = 8'h00;
        rx.rx_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst data", data, 0);
        check("rst strobe", dataStrobe, 0);
        check("rst type", dataType, 0);
        check("rst cv", cursorVisible, 1);
        check("rst cb", cursorBlock, 1);
        check("rst ul", underline, 0);
        check("rst fg", fgColor, 12'hFFF);
        check("rst bg", bgColor, 12'h000);
        check("rst ready", rx.rx_ready, 1);
        check("rst busy", busy, 0);
        tick(1);

        // "Hi", LF, BEL: two printables, one control, BEL dropped
        clear_stb();
        add_str("Hi");
        txq.push_back(8'h0A);
        txq.push_back(8'h07);
        send_q();
        wait_idle("hi");
        build_plain();
        check_strobes("hi");
        if (stb_cyc.size() > 0) check("hi latency", stb_cyc[0] - first_acc, 2);
        check_spacing("hi");

        // SGR colours and underline, then SGR 0
        clear_stb();
        txq.push_back(8'h1B);
        add_str("[31;44;4m");
        send_q();
        wait_idle("sgr");
        build_plain();
        if (ESC_EN) expq.delete();
        check_strobes("sgr");
        check("sgr fg", fgColor, ESC_EN ? 12'hF00 : 12'hFFF);
        check("sgr bg", bgColor, ESC_EN ? 12'h00F : 12'h000);
        check("sgr ul", underline, ESC_EN ? 1 : 0);
        clear_stb();
        txq.push_back(8'h1B);
        add_str("[0m");
        send_q();
        wait_idle("sgr0");
        check("sgr0 fg", fgColor, 12'hFFF);
        check("sgr0 bg", bgColor, 12'h000);
        check("sgr0 ul", underline, 0);
        check("sgr0 cv", cursorVisible, 1);

        // Private cursor modes, then clear screen
        clear_stb();
        txq.push_back(8'h1B);
        add_str("[?25l");
        txq.push_back(8'h1B);
        add_str("[?12l");
        send_q();
        wait_idle("dec");
        build_plain();
        if (ESC_EN) expq.delete();
        check_strobes("dec");
        check("dec cv", cursorVisible, ESC_EN ? 0 : 1);
        check("dec cb", cursorBlock, ESC_EN ? 0 : 1);
        clear_stb();
        txq.push_back(8'h1B);
        add_str("[2J");
        send_q();
        wait_idle("cls");
        build_plain();
        if (ESC_EN) begin
            expq.delete();
            expq.push_back(9'h10C);
        end
        check_strobes("cls");

        // 20-byte burst: FIFO fills, nothing lost, full-rate spacing
        clear_stb();
        add_str("abcdefghijklmnopqrst");
        send_q();
        check("burst full seen", saw_full, 1);
        wait_idle("burst");
        build_plain();
        check_strobes("burst");
        check_spacing("burst");

        // Saturating params, unknown final byte, junk byte, then 'A'
        clear_stb();
        txq.push_back(8'h1B);
        add_str("[300m");
        txq.push_back(8'h1B);
        add_str("[9999m");
        txq.push_back(8'h1B);
        add_str("[x");
        txq.push_back(8'h01);
        add_str("A");
        send_q();
        wait_idle("sat");
        build_plain();
        if (ESC_EN) begin
            expq.delete();
            expq.push_back(9'h041);
        end
        check_strobes("sat");
        check("sat fg", fgColor, 12'hFFF);
        check("sat bg", bgColor, 12'h000);
        check("sat ul", underline, 0);

        // CSI waits on an empty FIFO, then resumes
        clear_stb();
        txq.push_back(8'h1B);
        add_str("[3");
        send_q();
        tick(60);
        check("csi wait busy", busy, ESC_EN ? 1 : 0);
        txq.delete();
        add_str("1m");
        send_q();
        wait_idle("csi resume");
        check("csi resume fg", fgColor, ESC_EN ? 12'hF00 : 12'hFFF);

        // Reset with a sequence and bytes still queued behind a strobe gap
        clear_stb();
        add_str("X");
        txq.push_back(8'h1B);
        add_str("[34mYZ");
        send_q();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid-rst ready", rx.rx_ready, 1);
        check("mid-rst busy", busy, 0);
        check("mid-rst data", data, 0);
        check("mid-rst type", dataType, 0);
        check("mid-rst fg", fgColor, 12'hFFF);
        check("mid-rst bg", bgColor, 12'h000);
        check("mid-rst ul", underline, 0);
        check("mid-rst cv", cursorVisible, 1);
        check("mid-rst cb", cursorBlock, 1);
        tick(200);
        expq.delete();
        expq.push_back(9'h058);
        check_strobes("mid-rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
